// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// request at a time to the instruction memory and presents the fetched word
// (or a bubble) to the IF/ID register. Redirects from EX take priority over
// the shared IF/ID stall and cancel any response still in flight.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        bubble
);

    // IDLE: first cycle out of reset, REQ: request on the bus,
    // WAIT: granted and awaiting the response, HOLD: response captured
    // while stalled, KILL: awaiting a response that must be thrown away.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic [31:0] redir_pc_s;
    logic [31:0] fpc_inc_s;
    logic        req_s;
    logic        bubble_s;
    logic [31:0] inst_s;

    // Redirect targets are word aligned; the sequential PC wraps at 2^32.
    assign redir_pc_s = {redirect_pc[31:2], 2'b00};
    assign fpc_inc_s  = fpc_q + 32'd4;

    // State, fetch PC and held instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            hold_inst_q <= NOP_INST;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Next-state, next-PC and presentation logic; redirect outranks stall.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        hold_inst_d = hold_inst_q;
        req_s       = 1'b0;
        bubble_s    = 1'b1;
        inst_s      = NOP_INST;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    fpc_d = redir_pc_s;
                end else begin
                    fpc_d = fpc_q;
                end
            end

            REQ: begin
                req_s = 1'b1;
                if (redirect) begin
                    fpc_d = redir_pc_s;
                    // A grant alongside the redirect leaves a stale response
                    // outstanding, which KILL swallows.
                    if (imem_gnt) begin
                        state_d = KILL;
                    end else begin
                        state_d = REQ;
                    end
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end

            WAIT: begin
                if (redirect) begin
                    fpc_d = redir_pc_s;
                    // Response already here is dropped now; otherwise it is
                    // still coming and must be drained in KILL.
                    if (imem_rvalid) begin
                        state_d = REQ;
                    end else begin
                        state_d = KILL;
                    end
                end else if (imem_rvalid) begin
                    bubble_s = 1'b0;
                    inst_s   = imem_rdata;
                    if (stall) begin
                        hold_inst_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        fpc_d   = fpc_inc_s;
                        state_d = REQ;
                    end
                end else begin
                    state_d = WAIT;
                end
            end

            HOLD: begin
                bubble_s = 1'b0;
                inst_s   = hold_inst_q;
                if (redirect) begin
                    fpc_d   = redir_pc_s;
                    state_d = REQ;
                end else if (!stall) begin
                    fpc_d   = fpc_inc_s;
                    state_d = REQ;
                end else begin
                    state_d = HOLD;
                end
            end

            KILL: begin
                // Last redirect wins while draining the stale response.
                if (redirect) begin
                    fpc_d = redir_pc_s;
                end else begin
                    fpc_d = fpc_q;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end else begin
                    state_d = KILL;
                end
            end

            default: begin
                state_d = IDLE;
                fpc_d   = RESET_PC;
            end
        endcase
    end

    // Output drive: the IF/ID register samples these directly.
    always_comb begin
        imem_req  = req_s;
        imem_addr = fpc_q;
        pc        = fpc_q;
        pc4       = fpc_inc_s;
        bubble    = bubble_s;
        if (bubble_s) begin
            inst = NOP_INST;
        end else begin
            inst = inst_s;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. A small zero-wait memory
// responder (rdata = addr | 0x13) can be switched on; otherwise each cycle's
// grant/response is driven by hand.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        bubble;

    logic        auto_mem;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        pend_q;
    logic [31:0] pend_addr_q;

    int errors;
    int checks;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc4         (pc4),
        .inst        (inst),
        .bubble      (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt    = auto_mem ? imem_req : m_gnt;
    assign imem_rvalid = auto_mem ? pend_q : m_rvalid;
    assign imem_rdata  = auto_mem ? (pend_addr_q | 32'h0000_0013) : m_rdata;

    always @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_addr_q <= 32'h0;
        end else begin
            pend_q      <= auto_mem && imem_req && imem_gnt;
            pend_addr_q <= imem_addr;
        end
    end

    // Advance to 2 time units after the next rising edge and clear per-cycle inputs.
    task automatic tick();
        @(posedge clk);
        #2;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        m_gnt       = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = 32'h0;
    endtask

    // Two reset edges, then release; returns during the first IDLE cycle.
    task automatic apply_reset(input logic use_auto);
        auto_mem = use_auto;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        auto_mem = 1'b1;
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if ({imem_req, bubble, inst, pc, pc4} !== {1'b0, 1'b1, NOP, 32'h0, 32'h4}) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b bub=%0b inst=%h pc=%h pc4=%h, want 0 1 %h 0 4",
                     imem_req, bubble, inst, pc, pc4, NOP);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        // IDLE
        #1;
        checks++;
        if ({imem_req, bubble} !== 2'b01) begin
            errors++;
            $display("FAIL idle: got req=%0b bub=%0b, want 0 1", imem_req, bubble);
        end
        tick(); #1;
        checks++;
        if ({imem_req, imem_addr, bubble} !== {1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL req0: got req=%0b addr=%h bub=%0b, want 1 0 1", imem_req, imem_addr, bubble);
        end
        tick(); #1;
        checks++;
        if ({imem_req, bubble, pc, pc4, inst} !== {1'b0, 1'b0, 32'h0, 32'h4, 32'h13}) begin
            errors++;
            $display("FAIL resp0: got req=%0b bub=%0b pc=%h pc4=%h inst=%h, want 0 0 0 4 13",
                     imem_req, bubble, pc, pc4, inst);
        end
        tick(); #1;
        checks++;
        if ({imem_req, imem_addr, bubble} !== {1'b1, 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL req4: got req=%0b addr=%h bub=%0b, want 1 4 1", imem_req, imem_addr, bubble);
        end
        tick(); #1;
        checks++;
        if ({bubble, pc, pc4, inst} !== {1'b0, 32'h4, 32'h8, 32'h17}) begin
            errors++;
            $display("FAIL resp4: got bub=%0b pc=%h pc4=%h inst=%h, want 0 4 8 17", bubble, pc, pc4, inst);
        end
        tick(); #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL req8: got req=%0b addr=%h, want 1 8", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        // Response for 0x8 arrives this cycle; stall for 3 cycles.
        tick();
        for (int i = 0; i < 4; i++) begin
            stall = (i < 3);
            #1;
            checks++;
            if ({imem_req, bubble, inst, pc} !== {1'b0, 1'b0, 32'h1B, 32'h8}) begin
                errors++;
                $display("FAIL hold_%0d: got req=%0b bub=%0b inst=%h pc=%h, want 0 0 1b 8",
                         i, imem_req, bubble, inst, pc);
            end
            tick();
        end
        #1;
        checks++;
        if ({imem_req, imem_addr, bubble} !== {1'b1, 32'hC, 1'b1}) begin
            errors++;
            $display("FAIL after_hold: got req=%0b addr=%h bub=%0b, want 1 c 1", imem_req, imem_addr, bubble);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset(1'b0);
        tick();                     // REQ
        m_gnt = 1'b1;
        tick();                     // WAIT
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++;
        if ({imem_req, bubble} !== 2'b01) begin
            errors++;
            $display("FAIL rw_wait: got req=%0b bub=%0b, want 0 1", imem_req, bubble);
        end
        tick();                     // KILL
        #1;
        checks++;
        if ({imem_req, bubble} !== 2'b01) begin
            errors++;
            $display("FAIL rw_kill: got req=%0b bub=%0b, want 0 1", imem_req, bubble);
        end
        tick();                     // KILL, late response
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({imem_req, bubble, inst} !== {1'b0, 1'b1, NOP}) begin
            errors++;
            $display("FAIL rw_late: got req=%0b bub=%0b inst=%h, want 0 1 %h", imem_req, bubble, inst, NOP);
        end
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL rw_next: got req=%0b addr=%h, want 1 100", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_rvalid_stall();
        apply_reset(1'b0);
        tick();                     // REQ
        m_gnt = 1'b1;
        tick();                     // WAIT
        redirect = 1'b1; redirect_pc = 32'h203; stall = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'h5555_5555;
        #1;
        checks++;
        if ({bubble, inst} !== {1'b1, NOP}) begin
            errors++;
            $display("FAIL rrs_now: got bub=%0b inst=%h, want 1 %h", bubble, inst, NOP);
        end
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr, bubble} !== {1'b1, 32'h200, 1'b1}) begin
            errors++;
            $display("FAIL rrs_next: got req=%0b addr=%h bub=%0b, want 1 200 1", imem_req, imem_addr, bubble);
        end
    endtask

    task automatic test_redirect_req_kill();
        apply_reset(1'b0);
        tick();                     // REQ
        redirect = 1'b1; redirect_pc = 32'h40; m_gnt = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rk_req: got req=%0b addr=%h, want 1 0", imem_req, imem_addr);
        end
        tick();                     // KILL: response and a second redirect together
        redirect = 1'b1; redirect_pc = 32'h80; m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
        #1;
        checks++;
        if ({imem_req, bubble} !== 2'b01) begin
            errors++;
            $display("FAIL rk_kill: got req=%0b bub=%0b, want 0 1", imem_req, bubble);
        end
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL rk_next: got req=%0b addr=%h, want 1 80", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        apply_reset(1'b0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;   // redirect in IDLE
        tick();                     // REQ
        m_gnt = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_req: got req=%0b addr=%h, want 1 fffffffc", imem_req, imem_addr);
        end
        tick();                     // WAIT
        m_rvalid = 1'b1; m_rdata = 32'h1234_5013;
        #1;
        checks++;
        if ({bubble, pc, pc4, inst} !== {1'b0, 32'hFFFF_FFFC, 32'h0, 32'h1234_5013}) begin
            errors++;
            $display("FAIL wrap_resp: got bub=%0b pc=%h pc4=%h inst=%h, want 0 fffffffc 0 12345013",
                     bubble, pc, pc4, inst);
        end
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_next: got req=%0b addr=%h, want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        apply_reset(1'b0);
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();                     // REQ at 0x300
        m_gnt = 1'b1;
        tick();                     // WAIT
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, bubble} !== 2'b01) begin
            errors++;
            $display("FAIL rstw_wait: got req=%0b bub=%0b, want 0 1", imem_req, bubble);
        end
        tick();                     // in reset
        #1;
        checks++;
        if ({imem_req, bubble, pc} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rstw_rst: got req=%0b bub=%0b pc=%h, want 0 1 0", imem_req, bubble, pc);
        end
        tick();
        rst = 1'b0;                 // IDLE with stray response
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_0BAD;
        #1;
        checks++;
        if ({imem_req, bubble, inst} !== {1'b0, 1'b1, NOP}) begin
            errors++;
            $display("FAIL rstw_stray: got req=%0b bub=%0b inst=%h, want 0 1 %h", imem_req, bubble, inst, NOP);
        end
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr, bubble} !== {1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL rstw_first: got req=%0b addr=%h bub=%0b, want 1 0 1", imem_req, imem_addr, bubble);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        auto_mem = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_rvalid_stall();
        test_redirect_req_kill();
        test_wrap();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
